// File: rtl/pc_queue_ctrl_pkg.sv
// Shared constants and FSM encoding for the PC queue controller.
package pc_queue_ctrl_pkg;

  localparam int PC_W   = 8;
  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_SLOT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_queue_ctrl_if.sv
// Issue-side bus of the PC queue controller: pipeline requests in, issue/link/debug status out.
interface pc_queue_ctrl_if #(
  parameter int PC_W = pc_queue_ctrl_pkg::PC_W
);

  logic            stall_in;
  logic            branch_valid;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            bl_in;
  logic            nullify_in;

  logic [PC_W-1:0] pc_front;
  logic [PC_W-1:0] pc_back;
  logic            issue_valid;
  logic            nullify_out;
  logic            link_valid;
  logic [PC_W-1:0] link_addr;
  logic            proto_err;
  logic [1:0]      state_out;

  modport master (
    output stall_in, branch_valid, branch_taken, branch_target, bl_in, nullify_in,
    input  pc_front, pc_back, issue_valid, nullify_out, link_valid, link_addr,
           proto_err, state_out
  );

  modport slave (
    input  stall_in, branch_valid, branch_taken, branch_target, bl_in, nullify_in,
    output pc_front, pc_back, issue_valid, nullify_out, link_valid, link_addr,
           proto_err, state_out
  );

endinterface

// File: rtl/pc_queue_ctrl_pc_adder.sv
// Combinational W-bit address adder with a constant increment; wraps modulo 2^W.
module pc_adder #(
  parameter int            W   = 8,
  parameter logic [W-1:0]  INC = '0
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sum
);

  assign sum = a + INC;

endmodule

// File: rtl/pc_queue_ctrl.sv
// Two-entry PC queue (front issuing, back next) with delayed-branch slot, nullification and link generation.
module pc_queue_ctrl #(
  parameter int              PC_W     = pc_queue_ctrl_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  pc_queue_ctrl_if.slave  bus
);

  import pc_queue_ctrl_pkg::*;

  state_t          state, state_n;
  logic            from_slot, from_slot_n;
  logic [PC_W-1:0] pc_front_q, pc_front_n;
  logic [PC_W-1:0] pc_back_q, pc_back_n;
  logic            issue_q, issue_n;
  logic            nullify_q, nullify_n;
  logic            link_valid_q, link_valid_n;
  logic [PC_W-1:0] link_addr_q, link_addr_n;
  logic            proto_err_q, proto_err_n;
  logic [PC_W-1:0] pc_back_inc;
  logic [PC_W-1:0] pc_front_link;
  logic            branch_live;
  logic            redirect;

  pc_adder #(.W(PC_W), .INC(PC_W'(PC_INC))) u_back_inc (
    .a   (pc_back_q),
    .sum (pc_back_inc)
  );

  pc_adder #(.W(PC_W), .INC(PC_W'(2 * PC_INC))) u_link_addr (
    .a   (pc_front_q),
    .sum (pc_front_link)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      from_slot    <= 1'b0;
      pc_front_q   <= RESET_PC;
      pc_back_q    <= RESET_PC + PC_W'(PC_INC);
      issue_q      <= 1'b0;
      nullify_q    <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state        <= state_n;
      from_slot    <= from_slot_n;
      pc_front_q   <= pc_front_n;
      pc_back_q    <= pc_back_n;
      issue_q      <= issue_n;
      nullify_q    <= nullify_n;
      link_valid_q <= link_valid_n;
      link_addr_q  <= link_addr_n;
      proto_err_q  <= proto_err_n;
    end
  end

  // A nullified front instruction has no side effects, so its branch request is dropped.
  always_comb begin
    state_n      = state;
    from_slot_n  = from_slot;
    pc_front_n   = pc_front_q;
    pc_back_n    = pc_back_q;
    issue_n      = 1'b0;
    nullify_n    = nullify_q;
    link_valid_n = 1'b0;
    link_addr_n  = '0;
    proto_err_n  = 1'b0;
    branch_live  = bus.branch_valid && !nullify_q;
    redirect     = 1'b0;

    case (state)
      ST_INIT: begin
        state_n = ST_RUN;
        issue_n = 1'b1;
      end
      ST_RUN, ST_SLOT: begin
        if (bus.stall_in) begin
          state_n     = ST_STALL;
          from_slot_n = (state == ST_SLOT);
        end else begin
          redirect    = (state == ST_RUN) && branch_live && bus.branch_taken;
          proto_err_n = (state == ST_SLOT) && branch_live;
          issue_n     = 1'b1;
          pc_front_n  = pc_back_q;
          pc_back_n   = redirect ? bus.branch_target : pc_back_inc;
          nullify_n   = bus.nullify_in && !nullify_q;
          state_n     = redirect ? ST_SLOT : ST_RUN;
          if (redirect && bus.bl_in) begin
            link_valid_n = 1'b1;
            link_addr_n  = pc_front_link;
          end
        end
      end
      ST_STALL: begin
        if (!bus.stall_in) begin
          state_n     = from_slot ? ST_SLOT : ST_RUN;
          from_slot_n = 1'b0;
          issue_n     = 1'b1;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  assign bus.pc_front    = pc_front_q;
  assign bus.pc_back     = pc_back_q;
  assign bus.issue_valid = issue_q;
  assign bus.nullify_out = nullify_q;
  assign bus.link_valid  = link_valid_q;
  assign bus.link_addr   = link_addr_q;
  assign bus.proto_err   = proto_err_q;
  assign bus.state_out   = state;

endmodule

// File: doc/pc_queue_ctrl.md
PC_QUEUE_CTRL -- requirements
Module: pc_queue_ctrl

Interface
REQ-001 Parameter PC_W, default 8: width of all instruction addresses.
REQ-002 Parameter RESET_PC, default 8'h00: address of the first instruction issued after reset.
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 stall_in  in  1: hold the queue this cycle.
REQ-006 branch_valid  in  1: the instruction at pc_front has resolved a branch this cycle.
REQ-007 branch_taken  in  1: branch condition outcome; qualified by branch_valid.
REQ-008 branch_target  in  PC_W: target address (front+8+4*offset, computed externally).
REQ-009 bl_in  in  1: branch is a branch-and-link; qualified by branch_valid & branch_taken.
REQ-010 nullify_in  in  1: the instruction at pc_front nullifies its successor.
REQ-011 pc_front  out  PC_W: address of the instruction issuing this cycle.
REQ-012 pc_back  out  PC_W: address of the next instruction to issue.
REQ-013 issue_valid  out  1: pc_front holds a real instruction this cycle.
REQ-014 nullify_out  out  1: the instruction at pc_front is nullified; no architectural side effects.
REQ-015 link_valid  out  1: one-cycle pulse; link_addr is to be written to GR[t].
REQ-016 link_addr  out  PC_W: return address (branch pc_front + 8).
REQ-017 proto_err  out  1: one-cycle pulse on an illegal branch in a delay slot.
REQ-018 state_out  out  2: current FSM state, for debug.

Function
REQ-019 FSM states: INIT=0, RUN=1, STALL=2, SLOT=3.
REQ-020 INIT lasts exactly one cycle after reset: issue_valid=0, queue held, unconditional transition to RUN.
REQ-021 Sequential advance (RUN or SLOT, stall_in=0, no taken branch): pc_front<=pc_back; pc_back<=pc_back+4.
REQ-022 Taken branch (RUN, stall_in=0, branch_valid=1, branch_taken=1):
  - pc_front<=pc_back (delay slot); pc_back<=branch_target; next state SLOT.
REQ-023 Not-taken branch (branch_valid=1, branch_taken=0): sequential advance; state stays RUN.
REQ-024 Taken BL: link_valid=1 and link_addr=pc_front+8 in the cycle after acceptance.
REQ-025 Non-BL or not-taken branch: link_valid=0 and link_addr=0.
REQ-026 SLOT lasts one issue cycle; it then returns to RUN on advance, or to STALL if stall_in=1.
REQ-027 branch_valid=1 in SLOT: branch ignored, proto_err pulses next cycle, sequential advance applies.
REQ-028 Stall (stall_in=1 in RUN or SLOT):
  - pc_front, pc_back and nullify_out hold; issue_valid=0; enter STALL.
  - Remember whether the prior state was SLOT.
REQ-029 STALL with stall_in=0: return to the remembered state (RUN or SLOT) with no advance that cycle.
REQ-030 stall_in has priority over branch_valid and nullify_in; both are ignored while stalling (the requester holds them).
REQ-031 nullify_in=1 on an advancing cycle: nullify_out=1 for the next issued instruction, for its single issue cycle only.
REQ-032 Simultaneous taken branch and nullify_in: both apply; the delay slot issues with nullify_out=1.
REQ-033 A nullified instruction's branch_valid and nullify_in are ignored: no redirect, no link, no proto_err.
REQ-034 All address arithmetic is modulo 2^PC_W; FF+4 wraps to 03 with no flag.

Reset
REQ-035 Reset values:
  - pc_front=RESET_PC; pc_back=RESET_PC+4.
  - issue_valid=0; nullify_out=0; link_valid=0; link_addr=0; proto_err=0.
  - state=INIT; stalled-from-SLOT flag=0.
REQ-036 Reset asserted mid-operation (including in SLOT or STALL) overrides all inputs that cycle and discards any pending redirect, nullify or link.

Structure
REQ-037 Shared package holds PC_W, the state encodings and the instruction increment (4).
REQ-038 One sub-module, pc_adder (combinational PC_W-bit add of a constant), is instantiated for both pc_back+4 and pc_front+8.
REQ-039 All outputs are registered; no combinational input-to-output path.

Verification
REQ-040 Reset with RESET_PC=00, 4 idle cycles -> INIT for 1 cycle, then pc_front=00,04,08; issue_valid=0 then 1.
REQ-041 Taken BL at pc_front=10, target=40 -> next cycle: pc_front=14 (SLOT), link_valid=1, link_addr=18; then pc_front=40, state RUN.
REQ-042 Taken branch with nullify_in at pc_front=20 -> slot 24 issues with nullify_out=1; its branch_valid is ignored; then pc_front=target.
REQ-043 stall_in for 3 cycles while in SLOT -> pc holds, issue_valid=0; after release the state resumes SLOT, then advances to the target.
REQ-044 branch_valid in SLOT -> proto_err pulses once, sequential advance. pc_front=FC -> next FC+4 wraps to 00.
REQ-045 reset asserted while in SLOT -> next cycle all REQ-035 values; the pending target is never issued.
